// File: rtl/sme_param_engine.sv
// Parametrised string-matching engine: loads a string, then searches each streamed
// pattern one start position per cycle, reporting the leftmost match.
module sme_param_engine #(
  parameter int STR_LEN = 32,
  parameter int PAT_LEN = 8,
  parameter int CHAR_W  = 8,
  parameter int IDX_W   = $clog2(STR_LEN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CHAR_W-1:0] chardata,
  input  logic              isstring,
  input  logic              ispattern,
  input  logic              nocase,
  output logic              valid,
  output logic              match,
  output logic [IDX_W-1:0]  match_index,
  output logic              busy
);

  localparam int LEN_W = IDX_W + 1;
  localparam int PC_W  = $clog2(PAT_LEN + 1);
  localparam int PI_W  = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
  localparam int SW    = ((LEN_W > PC_W) ? LEN_W : PC_W) + 1;

  localparam logic [CHAR_W-1:0] CH_CARET  = CHAR_W'(8'h5E);
  localparam logic [CHAR_W-1:0] CH_DOLLAR = CHAR_W'(8'h24);
  localparam logic [CHAR_W-1:0] CH_DOT    = CHAR_W'(8'h2E);
  localparam logic [CHAR_W-1:0] CH_SPACE  = CHAR_W'(8'h20);

  typedef enum logic [2:0] {IDLE, LD_STR, LD_PAT, SEARCH, DONE} state_t;

  state_t state, state_nx;

  logic [CHAR_W-1:0] str_mem [STR_LEN];
  logic [CHAR_W-1:0] pat_mem [PAT_LEN];
  logic [LEN_W-1:0]  str_len;
  logic [PC_W-1:0]   raw_cnt;
  logic [PC_W-1:0]   core_cnt;
  logic              anchor_s;
  logic              last_dollar;
  logic              nocase_q;
  logic [IDX_W-1:0]  s;
  logic              found;
  logic [IDX_W-1:0]  found_idx;

  logic str_first, str_push, pat_first, pat_push, search_start;
  logic [PC_W-1:0]  core_len;
  logic [SW-1:0]    s_end;
  logic             fits, chars_ok, as_ok, ae_ok, hit, no_cand, last_cand;

  function automatic logic [CHAR_W-1:0] fold(input logic [CHAR_W-1:0] c, input logic en);
    fold = c;
    if (en && c >= CHAR_W'(8'h61) && c <= CHAR_W'(8'h7A))
      fold = c - CHAR_W'(8'h20);
  endfunction

  // A trailing '$' is stored as the last core char and excluded from L here.
  assign core_len = core_cnt - PC_W'(last_dollar);
  assign s_end    = SW'(s) + SW'(core_len);
  assign fits     = s_end <= SW'(str_len);
  assign no_cand  = (str_len == '0);
  assign last_cand = ({1'b0, s} == str_len - LEN_W'(1));

  always_comb begin
    chars_ok = 1'b1;
    for (int unsigned k = 0; k < PAT_LEN; k++) begin
      if (PC_W'(k) < core_len) begin
        if (!(pat_mem[k] == CH_DOT ||
              fold(pat_mem[k], nocase_q) == fold(str_mem[s + IDX_W'(k)], nocase_q)))
          chars_ok = 1'b0;
      end
    end
  end

  always_comb begin
    as_ok = 1'b1;
    if (anchor_s)
      as_ok = (s == '0) || (str_mem[s - IDX_W'(1)] == CH_SPACE);
  end

  always_comb begin
    ae_ok = 1'b1;
    if (last_dollar)
      ae_ok = (s_end == SW'(str_len)) || (str_mem[IDX_W'(s_end)] == CH_SPACE);
  end

  assign hit  = !no_cand && fits && chars_ok && as_ok && ae_ok;
  assign busy = (state == SEARCH) || (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    str_first    = 1'b0;
    str_push     = 1'b0;
    pat_first    = 1'b0;
    pat_push     = 1'b0;
    search_start = 1'b0;
    case (state)
      IDLE: begin
        if (isstring) begin
          str_first = 1'b1;
          state_nx  = LD_STR;
        end else if (ispattern) begin
          pat_first = 1'b1;
          state_nx  = LD_PAT;
        end
      end
      LD_STR: begin
        if (isstring) str_push = 1'b1;
        else          state_nx = IDLE;
      end
      LD_PAT: begin
        if (ispattern) begin
          pat_push = 1'b1;
        end else begin
          search_start = 1'b1;
          state_nx     = SEARCH;
        end
      end
      SEARCH: begin
        if (no_cand || hit || last_cand) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (str_first)
      str_mem[0] <= chardata;
    else if (str_push && str_len < LEN_W'(STR_LEN))
      str_mem[str_len[IDX_W-1:0]] <= chardata;
  end

  always_ff @(posedge clk) begin
    if (pat_first)
      pat_mem[0] <= chardata;
    else if (pat_push && raw_cnt < PC_W'(PAT_LEN))
      pat_mem[core_cnt[PI_W-1:0]] <= chardata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      str_len     <= '0;
      raw_cnt     <= '0;
      core_cnt    <= '0;
      anchor_s    <= 1'b0;
      last_dollar <= 1'b0;
      nocase_q    <= 1'b0;
      s           <= '0;
      found       <= 1'b0;
      found_idx   <= '0;
      valid       <= 1'b0;
      match       <= 1'b0;
      match_index <= '0;
    end else begin
      valid <= 1'b0;

      if (str_first)
        str_len <= LEN_W'(1);
      else if (str_push && str_len < LEN_W'(STR_LEN))
        str_len <= str_len + LEN_W'(1);

      // A leading '^' is consumed as an anchor and never occupies a core slot.
      if (pat_first) begin
        raw_cnt  <= PC_W'(1);
        nocase_q <= nocase;
        if (chardata == CH_CARET) begin
          anchor_s    <= 1'b1;
          core_cnt    <= '0;
          last_dollar <= 1'b0;
        end else begin
          anchor_s    <= 1'b0;
          core_cnt    <= PC_W'(1);
          last_dollar <= (chardata == CH_DOLLAR);
        end
      end else if (pat_push && raw_cnt < PC_W'(PAT_LEN)) begin
        raw_cnt     <= raw_cnt + PC_W'(1);
        core_cnt    <= core_cnt + PC_W'(1);
        last_dollar <= (chardata == CH_DOLLAR);
      end

      if (search_start)
        s <= '0;

      if (state == SEARCH) begin
        if (state_nx == DONE) begin
          found     <= hit;
          found_idx <= hit ? s : '0;
        end else begin
          s <= s + IDX_W'(1);
        end
      end

      if (state == DONE) begin
        valid       <= 1'b1;
        match       <= found;
        match_index <= found_idx;
      end
    end
  end

endmodule
